// File: rtl/cordic_phase_gen_pkg.sv
// rtl/cordic_phase_gen_pkg.sv - shared state encoding and angle constants for the CORDIC phase generator
package cordic_phase_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [23:0] ANGLE_90  = 24'h400000;
    localparam logic [23:0] ANGLE_180 = 24'h800000;

endpackage

// File: rtl/cordic_valid_delay.sv
// rtl/cordic_valid_delay.sv - fixed-depth valid shift register matching CORDIC pipeline latency
module cordic_valid_delay #(
    parameter int DEPTH = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            // single stage: just register the input
            always_comb sr_d = valid_i;
        end else begin : g_chain
            // shift toward the MSB every clock; MSB is the delayed valid
            always_comb sr_d = {sr_q[DEPTH-2:0], valid_i};
        end
    endgenerate

    // shift register state; reset flushes any in-flight valids
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - phase accumulator angle source with fixed/chirp modes and CORDIC latency tracking
module cordic_phase_gen
    import cordic_phase_gen_pkg::*;
#(
    parameter int WIDTH          = 24,
    parameter int CORDIC_LATENCY = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] ftw_i,
    input  logic             ftw_load_i,
    input  logic [WIDTH-1:0] chirp_step_i,
    input  logic [WIDTH-1:0] chirp_end_i,
    input  logic [WIDTH-1:0] phase_off_i,
    output logic [WIDTH-1:0] angle_o,
    output logic             angle_valid_o,
    output logic             out_valid_o,
    output logic             wrap_o,
    output logic             busy_o
);

    localparam int                CNT_W    = $clog2(CORDIC_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CORDIC_LATENCY - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   phase_q, phase_d;
    logic [WIDTH-1:0]   freq_q,  freq_d;
    logic [WIDTH-1:0]   off_q,   off_d;
    logic               wrap_q,  wrap_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // one extra bit on both sums: carry-out for wrap, and a no-wrap chirp end compare
    logic [WIDTH:0]     phase_sum;
    logic [WIDTH:0]     chirp_sum;
    logic               chirp_done;

    assign phase_sum  = {1'b0, phase_q} + {1'b0, freq_q};
    assign chirp_sum  = {1'b0, freq_q} + {1'b0, chirp_step_i};
    assign chirp_done = (chirp_sum >= {1'b0, chirp_end_i});

    // next-state and datapath update for the generator FSM
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        freq_d  = freq_q;
        off_d   = off_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    phase_d = '0;
                    off_d   = phase_off_i;
                    freq_d  = ftw_i;
                    state_d = mode_i ? ST_SWEEP : ST_RUN;
                end else if (ftw_load_i) begin
                    freq_d = ftw_i;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    phase_d = phase_sum[WIDTH-1:0];
                    wrap_d  = phase_sum[WIDTH];
                    if (ftw_load_i) begin
                        freq_d = ftw_i;
                    end
                end
            end
            ST_SWEEP: begin
                if (stop_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    phase_d = phase_sum[WIDTH-1:0];
                    wrap_d  = phase_sum[WIDTH];
                    if (chirp_done) begin
                        freq_d  = chirp_end_i;
                        state_d = ST_RUN;
                    end else begin
                        freq_d = chirp_sum[WIDTH-1:0];
                    end
                end
            end
            ST_DRAIN: begin
                // hold busy until the last live angle has left the CORDIC pipe
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // generator registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            freq_q  <= '0;
            off_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            freq_q  <= freq_d;
            off_q   <= off_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign angle_o       = phase_q + off_q;
    assign angle_valid_o = (state_q == ST_RUN) || (state_q == ST_SWEEP);
    assign wrap_o        = wrap_q;
    assign busy_o        = (state_q != ST_IDLE);

    cordic_valid_delay #(
        .DEPTH (CORDIC_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .reset   (reset),
        .valid_i (angle_valid_o),
        .valid_o (out_valid_o)
    );

endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb/tb_cordic_phase_gen.sv - self-checking bench for cordic_phase_gen
module tb_cordic_phase_gen;

    localparam int LAT = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [23:0] ftw_i = '0;
    logic        ftw_load_i = 1'b0;
    logic [23:0] chirp_step_i = '0;
    logic [23:0] chirp_end_i = '0;
    logic [23:0] phase_off_i = '0;
    logic [23:0] angle_o;
    logic        angle_valid_o;
    logic        out_valid_o;
    logic        wrap_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_cyc = 0;
    bit ev [0:8191];

    cordic_phase_gen dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .mode_i        (mode_i),
        .ftw_i         (ftw_i),
        .ftw_load_i    (ftw_load_i),
        .chirp_step_i  (chirp_step_i),
        .chirp_end_i   (chirp_end_i),
        .phase_off_i   (phase_off_i),
        .angle_o       (angle_o),
        .angle_valid_o (angle_valid_o),
        .out_valid_o   (out_valid_o),
        .wrap_o        (wrap_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // one clock; expected valid/busy for the new cycle, out_valid from the expected-valid history
    task automatic step(input logic exp_av, input logic exp_busy);
        logic exp_ov;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) rst_cyc = cyc;
        ev[cyc % 8192] = exp_av;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        ftw_load_i = 1'b0;
        chk("angle_valid", {31'd0, angle_valid_o}, {31'd0, exp_av});
        chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
        exp_ov = (cyc - LAT >= rst_cyc) ? ev[(cyc - LAT) % 8192] : 1'b0;
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, exp_ov});
    endtask

    // sample k of a stream: freq is ftw, then ftw2 after load_at (fixed), or min(ftw+k*step, end) for k>0 (chirp)
    task automatic run_stream(input int n, input logic [23:0] off, input logic [23:0] ftw,
                              input logic [23:0] stp, input logic [23:0] fend, input bit chirp,
                              input int load_at, input logic [23:0] ftw2);
        longint ph = 0;
        longint f;
        longint sum;
        bit     ew = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (chirp) begin
                f = (k == 0) ? longint'(ftw) : longint'(ftw) + longint'(k) * longint'(stp);
                if (k > 0 && f > longint'(fend)) f = longint'(fend);
            end else begin
                f = (load_at >= 0 && k > load_at) ? longint'(ftw2) : longint'(ftw);
            end
            chk("angle", {8'd0, angle_o}, 32'((longint'(off) + ph) & 64'hFFFFFF));
            chk("wrap", {31'd0, wrap_o}, {31'd0, ew});
            if (k == load_at) begin
                ftw_i      = ftw2;
                ftw_load_i = 1'b1;
            end
            sum = ph + f;
            ew  = sum[24];
            ph  = sum & 64'hFFFFFF;
            step(1'b1, 1'b1);
        end
    endtask

    // stop (optionally with a simultaneous ftw_load), drain LAT clocks with a stray start, back to idle
    task automatic stop_and_drain(input bit with_load);
        stop_i = 1'b1;
        if (with_load) begin
            ftw_i      = 24'hABCDEF;
            ftw_load_i = 1'b1;
        end
        step(1'b0, 1'b1);
        chk("wrap_at_drain", {31'd0, wrap_o}, 32'd0);
        for (int i = 0; i < LAT - 1; i++) begin
            if (i == 5) start_i = 1'b1;
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic do_start(input bit chirp, input logic [23:0] ftw, input logic [23:0] off, input bit with_stop);
        mode_i      = chirp;
        ftw_i       = ftw;
        phase_off_i = off;
        start_i     = 1'b1;
        stop_i      = with_stop;
        step(1'b1, 1'b1);
    endtask

    initial begin
        logic [23:0] r_ftw, r_ftw2, r_off, r_step, r_end;

        // reset state
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("reset_angle", {8'd0, angle_o}, 32'd0);
        chk("reset_wrap", {31'd0, wrap_o}, 32'd0);
        reset = 1'b0;
        stop_i = 1'b1;
        step(1'b0, 1'b0);

        // fixed frequency 1/16 turn per clock, wraps every 16 samples
        do_start(1'b0, 24'h100000, 24'h000000, 1'b0);
        run_stream(36, 24'h000000, 24'h100000, 24'h0, 24'h0, 1'b0, -1, 24'h0);
        stop_and_drain(1'b0);

        // constant 90 deg angle
        do_start(1'b0, 24'h000000, 24'h400000, 1'b0);
        run_stream(30, 24'h400000, 24'h000000, 24'h0, 24'h0, 1'b0, -1, 24'h0);
        stop_and_drain(1'b0);

        // directed chirp 0x100 -> 0x400, stop together with ftw_load
        chirp_step_i = 24'h000100;
        chirp_end_i  = 24'h000400;
        do_start(1'b1, 24'h000100, 24'h000000, 1'b0);
        run_stream(8, 24'h000000, 24'h000100, 24'h000100, 24'h000400, 1'b1, -1, 24'h0);
        stop_and_drain(1'b1);

        // chirp whose start frequency is already past the end: clamps on first sweep clock
        chirp_step_i = 24'h000010;
        chirp_end_i  = 24'h001000;
        do_start(1'b1, 24'h200000, 24'h123456, 1'b0);
        run_stream(8, 24'h123456, 24'h200000, 24'h000010, 24'h001000, 1'b1, -1, 24'h0);
        stop_and_drain(1'b0);

        // random fixed frequency with mid-run retune; start and stop together in idle
        r_ftw  = 24'($urandom);
        r_ftw2 = 24'($urandom);
        r_off  = 24'($urandom);
        do_start(1'b0, r_ftw, r_off, 1'b1);
        run_stream(40, r_off, r_ftw, 24'h0, 24'h0, 1'b0, 10, r_ftw2);
        stop_and_drain(1'b0);

        // random chirps
        for (int t = 0; t < 3; t++) begin
            r_ftw  = 24'($urandom_range(0, 24'h3FFFFF));
            r_step = 24'($urandom_range(0, 24'h1FFFFF));
            r_end  = 24'($urandom);
            r_off  = 24'($urandom);
            chirp_step_i = r_step;
            chirp_end_i  = r_end;
            do_start(1'b1, r_ftw, r_off, 1'b0);
            run_stream(40, r_off, r_ftw, r_step, r_end, 1'b1, -1, 24'h0);
            stop_and_drain(1'b0);
        end

        // reset in the middle of a sweep
        chirp_step_i = 24'h000010;
        chirp_end_i  = 24'hFFFFFF;
        do_start(1'b1, 24'h000010, 24'h0F0F0F, 1'b0);
        run_stream(6, 24'h0F0F0F, 24'h000010, 24'h000010, 24'hFFFFFF, 1'b1, -1, 24'h0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        chk("midreset_angle", {8'd0, angle_o}, 32'd0);
        chk("midreset_wrap", {31'd0, wrap_o}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < LAT + 5; i++) step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
